vram_blitter: RTL and testbench

//  Hardware fill/copy engine for the 4 KB text videoram (#8000-#8FFF).

---
 rtl/vram_pkg.sv | 24 ++
 rtl/vram_blitter.sv | 150 +++++++++++++++
 tb/tb_vram_blitter.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/vram_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | vram_pkg                                                                 |
// | Shared encodings and defaults for the videoram fill/copy engine.         |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
package vram_pkg;

  localparam int VRAM_AW = 12;
  localparam int VRAM_DW = 8;

  localparam logic OP_FILL = 1'b0;
  localparam logic OP_COPY = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_FILL = 3'd1,
    ST_RD   = 3'd2,
    ST_WR   = 3'd3,
    ST_DONE = 3'd4
  } state_t;

endpackage
`default_nettype wire

// File: rtl/vram_blitter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | vram_blitter                                                             |
// | Fill/copy engine sharing the videoram write port; the CPU always wins.   |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module vram_blitter
  import vram_pkg::*;
#(
  parameter int AW = VRAM_AW,
  parameter int DW = VRAM_DW
) (
  input  logic          i_clock,
  input  logic          i_reset,
  input  logic          i_cpu_sel,
  input  logic [AW-1:0] i_cpu_addr,
  input  logic [DW-1:0] i_cpu_wdata,
  input  logic          i_cpu_wren,
  output logic [DW-1:0] o_cpu_rdata,
  input  logic          i_cmd_start,
  input  logic          i_cmd_op,
  input  logic [AW-1:0] i_cmd_src,
  input  logic [AW-1:0] i_cmd_dst,
  input  logic [AW:0]   i_cmd_len,
  input  logic [1:0]    i_cmd_step,
  input  logic [DW-1:0] i_cmd_fill,
  input  logic          i_cmd_abort,
  output logic          o_busy,
  output logic          o_done,
  output logic [AW-1:0] o_mem_addr,
  output logic [DW-1:0] o_mem_wdata,
  output logic          o_mem_wren,
  input  logic [DW-1:0] i_mem_rdata
);

  state_t        r_state, w_state_nxt;
  logic [AW-1:0] r_src, r_dst;
  logic [AW:0]   r_len;
  logic [1:0]    r_step;
  logic [DW-1:0] r_fill, r_rbuf;
  logic          r_op, r_rd_pend;

  logic          w_gnt, w_last, w_start;
  logic [AW-1:0] w_inc;
  logic [AW-1:0] w_eng_addr;
  logic [DW-1:0] w_eng_wdata;
  logic          w_eng_wren;

  assign w_gnt   = ~i_cpu_sel;
  assign w_last  = (r_len == {{AW{1'b0}}, 1'b1});
  assign w_start = i_cmd_start & ~i_cmd_abort;
  assign w_inc   = {{(AW-2){1'b0}}, r_step};

  always_comb begin
    w_state_nxt = r_state;
    w_eng_addr  = r_dst;
    w_eng_wdata = r_fill;
    w_eng_wren  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_start) begin
          if (i_cmd_len == '0)          w_state_nxt = ST_DONE;
          else if (i_cmd_op == OP_COPY) w_state_nxt = ST_RD;
          else                          w_state_nxt = ST_FILL;
        end
      end
      ST_FILL: begin
        w_eng_wren = 1'b1;
        if (w_gnt && w_last) w_state_nxt = ST_DONE;
      end
      ST_RD: begin
        w_eng_addr = r_src;
        if (w_gnt) w_state_nxt = ST_WR;
      end
      ST_WR: begin
        // Read data is only on the bus in the cycle right after the read grant.
        w_eng_wdata = r_rd_pend ? i_mem_rdata : r_rbuf;
        w_eng_wren  = 1'b1;
        if (w_gnt) w_state_nxt = w_last ? ST_DONE : ST_RD;
      end
      ST_DONE: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
    if (i_cmd_abort) w_state_nxt = ST_IDLE;
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state   <= ST_IDLE;
      r_src     <= '0;
      r_dst     <= '0;
      r_len     <= '0;
      r_step    <= '0;
      r_fill    <= '0;
      r_rbuf    <= '0;
      r_op      <= OP_FILL;
      r_rd_pend <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      case (r_state)
        ST_IDLE: begin
          if (w_start) begin
            r_src  <= i_cmd_src;
            r_dst  <= i_cmd_dst;
            r_len  <= i_cmd_len;
            r_step <= (i_cmd_step == 2'd0) ? 2'd1 : i_cmd_step;
            r_fill <= i_cmd_fill;
            r_op   <= i_cmd_op;
          end
        end
        ST_FILL: begin
          if (w_gnt) begin
            r_dst <= r_dst + w_inc;
            r_len <= r_len - 1'b1;
          end
        end
        ST_RD: begin
          if (w_gnt) r_rd_pend <= 1'b1;
        end
        ST_WR: begin
          // Capture regardless of grant: the CPU may own the port this cycle.
          if (r_rd_pend) begin
            r_rbuf    <= i_mem_rdata;
            r_rd_pend <= 1'b0;
          end
          if (w_gnt) begin
            r_src <= r_src + w_inc;
            r_dst <= r_dst + w_inc;
            r_len <= r_len - 1'b1;
          end
        end
        default: ;
      endcase
      if (i_cmd_abort) r_rd_pend <= 1'b0;
    end
  end

  assign o_busy      = (r_state == ST_FILL) || (r_state == ST_RD) || (r_state == ST_WR);
  assign o_done      = (r_state == ST_DONE);
  assign o_cpu_rdata = i_mem_rdata;
  assign o_mem_addr  = i_cpu_sel ? i_cpu_addr  : w_eng_addr;
  assign o_mem_wdata = i_cpu_sel ? i_cpu_wdata : w_eng_wdata;
  assign o_mem_wren  = i_cpu_sel ? i_cpu_wren  : w_eng_wren;

  // The op latch is kept for visibility; the state already encodes fill vs copy.
  logic w_unused;
  assign w_unused = r_op;

endmodule
`default_nettype wire

// File: tb/tb_vram_blitter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_vram_blitter                                                          |
// | Scoreboard bench: expected engine writes queued at command time.         |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_vram_blitter;

  typedef struct packed {
    logic [11:0] a;
    logic [7:0]  d;
  } wr_t;

  logic        clk = 1'b0;
  logic        rst, mem_init;
  logic        cpu_sel, cpu_wren;
  logic [11:0] cpu_addr;
  logic [7:0]  cpu_wdata, cpu_rdata;
  logic        cmd_start, cmd_op, cmd_abort;
  logic [11:0] cmd_src, cmd_dst;
  logic [12:0] cmd_len;
  logic [1:0]  cmd_step;
  logic [7:0]  cmd_fill;
  logic        busy, done;
  logic [11:0] mem_addr;
  logic [7:0]  mem_wdata, mem_rdata;
  logic        mem_wren;

  logic [7:0]  tb_mem [0:4095];
  logic [7:0]  mdl    [0:4095];
  wr_t         sbq[$];
  int          total = 0;
  int          bad = 0;
  int          done_cnt = 0;
  bit          sb_off = 1'b0;

  always #5 clk = ~clk;

  vram_blitter dut (
    .i_clock(clk), .i_reset(rst),
    .i_cpu_sel(cpu_sel), .i_cpu_addr(cpu_addr), .i_cpu_wdata(cpu_wdata),
    .i_cpu_wren(cpu_wren), .o_cpu_rdata(cpu_rdata),
    .i_cmd_start(cmd_start), .i_cmd_op(cmd_op), .i_cmd_src(cmd_src),
    .i_cmd_dst(cmd_dst), .i_cmd_len(cmd_len), .i_cmd_step(cmd_step),
    .i_cmd_fill(cmd_fill), .i_cmd_abort(cmd_abort),
    .o_busy(busy), .o_done(done),
    .o_mem_addr(mem_addr), .o_mem_wdata(mem_wdata), .o_mem_wren(mem_wren),
    .i_mem_rdata(mem_rdata)
  );

  function automatic logic [7:0] pat(input int i);
    return 8'((i * 13 + 5) ^ (i >> 4));
  endfunction

  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 4096; i++) tb_mem[i] <= pat(i);
    end else if (mem_wren) begin
      tb_mem[mem_addr] <= mem_wdata;
    end
    mem_rdata <= tb_mem[mem_addr];
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (done) done_cnt++;
    if (!rst && !sb_off && mem_wren && !cpu_sel) begin
      if (sbq.size() == 0) begin
        check_eq("sb_extra_write", {20'd0, mem_addr}, 32'hFFFF_FFFF);
      end else begin
        wr_t e;
        e = sbq.pop_front();
        check_eq("wr_addr", {20'd0, mem_addr}, {20'd0, e.a});
        check_eq("wr_data", {24'd0, mem_wdata}, {24'd0, e.d});
      end
    end
  end

  // Model the engine sequentially on mdl so overlapping copies replicate too.
  task automatic start_op(input logic op, input logic [11:0] src, input logic [11:0] dst,
                          input int len, input logic [1:0] step, input logic [7:0] fill,
                          input int nexp);
    logic [11:0] s, d, st;
    wr_t e;
    s  = src;
    d  = dst;
    st = (step == 2'd0) ? 12'd1 : {10'd0, step};
    for (int i = 0; i < nexp; i++) begin
      e.a = d;
      e.d = op ? mdl[s] : fill;
      mdl[d] = e.d;
      sbq.push_back(e);
      s = s + st;
      d = d + st;
    end
    cmd_op = op; cmd_src = src; cmd_dst = dst; cmd_len = 13'(len);
    cmd_step = step; cmd_fill = fill; cmd_start = 1'b1;
    @(posedge clk); #1;
    cmd_start = 1'b0;
  endtask

  task automatic wait_done(input int limit, input bit alt, input bit spur, output int cyc);
    int j;
    bit rd_chk;
    logic [7:0] rd_exp;
    logic [11:0] a;
    cyc = 1; j = 0; rd_chk = 1'b0; rd_exp = '0;
    while (!done && cyc < limit) begin
      cmd_start = spur && (cyc == 2);
      if (spur && cyc == 2) begin
        cmd_op = 1'b1; cmd_dst = 12'h123; cmd_src = 12'h456; cmd_len = 13'd7;
      end
      if (alt && (cyc % 2 == 1)) begin
        cpu_sel = 1'b1;
        a = 12'(3000 + j / 2);
        cpu_addr = a;
        if (j % 2 == 0) begin
          cpu_wren = 1'b1;
          cpu_wdata = 8'(j * 7 + 3);
          mdl[a] = cpu_wdata;
        end else begin
          cpu_wren = 1'b0;
          rd_chk = 1'b1;
          rd_exp = mdl[a];
        end
        j++;
      end else begin
        cpu_sel = 1'b0;
        cpu_wren = 1'b0;
      end
      @(posedge clk); #1;
      cyc++;
      if (rd_chk) begin
        check_eq("cpu_rdata", {24'd0, cpu_rdata}, {24'd0, rd_exp});
        rd_chk = 1'b0;
      end
    end
    cmd_start = 1'b0; cpu_sel = 1'b0; cpu_wren = 1'b0;
    check_eq("done_seen", {31'd0, done}, 32'd1);
    check_eq("busy_at_done", {31'd0, busy}, 32'd0);
    @(posedge clk); #1;
    check_eq("done_one_cycle", {31'd0, done}, 32'd0);
    check_eq("busy_after_done", {31'd0, busy}, 32'd0);
  endtask

  task automatic check_mem(input string tag);
    int errs;
    errs = 0;
    for (int i = 0; i < 4096; i++) if (tb_mem[i] !== mdl[i]) errs++;
    check_eq(tag, errs, 0);
    check_eq({tag, "_sb_empty"}, sbq.size(), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    int cyc, dc;
    rst = 1'b1; mem_init = 1'b1;
    cpu_sel = 0; cpu_wren = 0; cpu_addr = '0; cpu_wdata = '0;
    cmd_start = 0; cmd_op = 0; cmd_abort = 0; cmd_src = '0; cmd_dst = '0;
    cmd_len = '0; cmd_step = '0; cmd_fill = '0;
    for (int i = 0; i < 4096; i++) mdl[i] = pat(i);
    repeat (3) @(posedge clk);
    #1;
    mem_init = 1'b0;
    check_eq("rst_busy", {31'd0, busy}, 32'd0);
    check_eq("rst_done", {31'd0, done}, 32'd0);
    check_eq("rst_wren", {31'd0, mem_wren}, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    check_eq("idle_busy", {31'd0, busy}, 32'd0);

    // One-line scroll on the initial pattern
    start_op(1'b1, 12'd160, 12'd0, 3840, 2'd1, 8'h00, 3840);
    wait_done(20000, 1'b0, 1'b0, cyc);
    check_eq("copy_cycles", cyc, 7681);
    check_mem("copy_mem");

    start_op(1'b0, 12'd0, 12'd0, 4000, 2'd1, 8'h20, 4000);
    wait_done(10000, 1'b0, 1'b0, cyc);
    check_eq("fill_cycles", cyc, 4001);
    check_mem("fill_mem");

    start_op(1'b0, 12'd0, 12'd1, 2000, 2'd2, 8'h17, 2000);
    wait_done(10000, 1'b0, 1'b0, cyc);
    check_eq("fill_step2_cycles", cyc, 2001);
    check_mem("fill_step2_mem");

    // CPU takes every other cycle, including the read-capture cycle
    start_op(1'b1, 12'd1000, 12'd500, 200, 2'd1, 8'h00, 200);
    wait_done(2000, 1'b1, 1'b0, cyc);
    check_eq("copy_alt_cycles", cyc, 801);
    check_mem("copy_alt_mem");

    // Wrap at top of memory, step 0 acts as 1, spurious start ignored
    start_op(1'b0, 12'd0, 12'hFFE, 4, 2'd0, 8'h5A, 4);
    wait_done(100, 1'b0, 1'b1, cyc);
    check_eq("wrap_cycles", cyc, 5);
    check_mem("wrap_mem");

    start_op(1'b0, 12'd0, 12'd50, 0, 2'd1, 8'h99, 0);
    wait_done(100, 1'b0, 1'b0, cyc);
    check_eq("len0_cycles", cyc, 1);
    check_mem("len0_mem");

    // Abort while element 10 is being granted: 11 writes stand
    dc = done_cnt;
    start_op(1'b0, 12'd0, 12'd100, 50, 2'd1, 8'hAA, 11);
    repeat (10) begin @(posedge clk); #1; end
    cmd_abort = 1'b1;
    cmd_start = 1'b1;
    @(posedge clk); #1;
    cmd_abort = 1'b0;
    cmd_start = 1'b0;
    check_eq("abort_busy", {31'd0, busy}, 32'd0);
    repeat (5) begin @(posedge clk); #1; end
    check_eq("abort_no_done", done_cnt, dc);
    check_eq("abort_still_idle", {31'd0, busy}, 32'd0);
    check_mem("abort_mem");

    // Reset mid-copy; partial memory contents are not tracked after this
    sb_off = 1'b1;
    start_op(1'b1, 12'd160, 12'd0, 100, 2'd1, 8'h00, 0);
    repeat (20) begin @(posedge clk); #1; end
    check_eq("pre_reset_busy", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    check_eq("mid_rst_busy", {31'd0, busy}, 32'd0);
    check_eq("mid_rst_done", {31'd0, done}, 32'd0);
    rst = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    check_eq("post_rst_busy", {31'd0, busy}, 32'd0);
    check_eq("post_rst_wren", {31'd0, mem_wren}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
